// File: rtl/instr_fetch_if.sv
// Bus bundle between the instruction fetch stage, instruction memory, decode and the
// jump-redirect source. The master modport is the fetch stage itself.
interface instr_fetch_if #(
    parameter int unsigned ADDR_W = 12
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [15:0]       imem_rdata;
    logic              instr_valid;
    logic [15:0]       instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_ready;
    logic              jump_valid;
    logic [ADDR_W-1:0] jump_target;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, instr_ready, jump_valid, jump_target
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
        output imem_gnt, imem_rvalid, imem_rdata, instr_ready, jump_valid, jump_target
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: program counter, single-outstanding instruction memory reads
// and a small FIFO of {word, address} for the opcode decoder.
// Optional feature macro: IFETCH_JFOLD_EN folds J (opcode 4'b1000) words into the pc
// instead of pushing them.
module instr_fetch #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DEPTH  = 4
) (
    input logic          clk,
    input logic          rst,
    instr_fetch_if.master bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [PtrW-1:0]   wptr_q, wptr_d;
    logic [PtrW-1:0]   rptr_q, rptr_d;
    logic              outstanding_q, outstanding_d;
    logic              drop_q, drop_d;
    logic              init_q;

    logic [15:0]       word_q [DEPTH];
    logic [ADDR_W-1:0] addr_q [DEPTH];

    logic req, accept, rsp, pop, push, is_j;

    // Request/handshake decode; init_q holds off requests for the first cycle after reset.
    always_comb begin
        rsp    = bus.imem_rvalid && outstanding_q;
        req    = init_q && !rst && !outstanding_q && (count_q < CntW'(DEPTH)) && !bus.jump_valid;
        accept = req && bus.imem_gnt;
        pop    = (count_q != '0) && bus.instr_ready;
`ifdef IFETCH_JFOLD_EN
        is_j   = (bus.imem_rdata[15:12] == 4'b1000);
`else
        is_j   = 1'b0;
`endif
        push   = rsp && !drop_q && !bus.jump_valid && !is_j;
    end

    // Next-state: redirect flushes the FIFO and overrides everything else.
    always_comb begin
        pc_d          = pc_q;
        req_addr_d    = req_addr_q;
        count_d       = count_q;
        wptr_d        = wptr_q;
        rptr_d        = rptr_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        if (bus.jump_valid) begin
            pc_d    = bus.jump_target;
            count_d = '0;
            wptr_d  = '0;
            rptr_d  = '0;
            if (outstanding_q && !bus.imem_rvalid) begin
                drop_d = 1'b1;
            end else if (rsp) begin
                outstanding_d = 1'b0;
                drop_d        = 1'b0;
            end
        end else begin
            if (accept) begin
                outstanding_d = 1'b1;
                req_addr_d    = pc_q;
                pc_d          = pc_q + ADDR_W'(1);
            end
            if (rsp) begin
                outstanding_d = 1'b0;
                drop_d        = 1'b0;
                if (!drop_q && is_j) begin
                    pc_d = bus.imem_rdata[ADDR_W-1:0];
                end
            end
            if (push) begin
                wptr_d = wptr_q + PtrW'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + PtrW'(1);
            end
            count_d = count_q + CntW'(push) - CntW'(pop);
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= '0;
            req_addr_q    <= '0;
            count_q       <= '0;
            wptr_q        <= '0;
            rptr_q        <= '0;
            outstanding_q <= 1'b0;
            drop_q        <= 1'b0;
            init_q        <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            req_addr_q    <= req_addr_d;
            count_q       <= count_d;
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            init_q        <= 1'b1;
        end
    end

    // FIFO storage; contents need no reset since count gates validity.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            word_q[wptr_q] <= bus.imem_rdata;
            addr_q[wptr_q] <= req_addr_q;
        end
    end

    // Outputs.
    always_comb begin
        bus.imem_req    = req;
        bus.imem_addr   = pc_q;
        bus.instr_valid = !rst && (count_q != '0);
        bus.instr       = word_q[rptr_q];
        bus.instr_pc    = addr_q[rptr_q];
    end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the vector processor: keeps the program counter, issues single-outstanding reads to instruction memory, and buffers returned 16-bit instruction words in a small FIFO. It feeds the opcode decoder, which receives `instr[15:12]` from this block. Jump redirects arrive from downstream. Optionally, the block folds J instructions itself.

## Interface
- `ADDR_W`, 12: instruction address width in words; must be ≤ 12.
- `DEPTH`, 4: FIFO depth; power of 2, ≥ 2.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_req`  out  1  read request, combinational from state.
- `imem_addr`  out  ADDR_W  word address; equals `pc`.
- `imem_gnt`  in  1  memory accepts the request this cycle.
- `imem_rvalid`  in  1  read data valid.
- `imem_rdata`  in  16  returned instruction word.
- `instr_valid`  out  1  FIFO head valid.
- `instr`  out  16  FIFO head word; opcode is `[15:12]`.
- `instr_pc`  out  ADDR_W  address of the FIFO head word.
- `instr_ready`  in  1  decode consumes the head.
- `jump_valid`  in  1  one-cycle redirect from downstream.
- `jump_target`  in  ADDR_W  redirect address.

## Operation
- State: `pc`, FIFO (word and address per entry), `count`, `outstanding`, `drop`.
- Reset values: `pc` = 0, `count` = 0, `outstanding` = 0, `drop` = 0. Outputs during reset and in the first cycle after it: `instr_valid` = 0, `imem_req` = 0 (both follow from the reset state).
- Request rule: `imem_req` = !`outstanding` && `count` < DEPTH && !`jump_valid`. Reserving a slot guarantees every accepted response fits in the FIFO.
- Accept: on `imem_req` && `imem_gnt`, set `outstanding` ← 1 and `pc` ← `pc`+1. The counter wraps modulo 2^ADDR_W, so 0xFFF is followed by 0x000.
- Response: on `imem_rvalid`, set `outstanding` ← 0.
  - If `drop` = 1, discard the data and clear `drop`.
  - Otherwise push {`imem_rdata`, address of the request}.
- Pop: on `instr_valid` && `instr_ready`. Push and pop in the same cycle leave `count` unchanged, including at `count` = DEPTH.
- Redirect, on `jump_valid`:
  - FIFO flushed (`count` ← 0, any same-cycle pop ignored) and `pc` ← `jump_target`.
  - No request is issued that cycle.
  - If `outstanding` && !`imem_rvalid`, set `drop` ← 1.
  - A response arriving in the redirect cycle is discarded.
- `imem_rvalid` with `outstanding` = 0 is a protocol error. The data is ignored and state is unchanged.

## Timing
- At most one read in flight.
- A new request is issued no earlier than the cycle after the response, so peak rate is one word per 2 cycles with zero-wait memory.
- Latency: a word pushed on cycle N is presented (`instr_valid` = 1) on cycle N+1.
- After `jump_valid` on cycle N, the first request to `jump_target` is issued on cycle N+1, or on the cycle after the dropped response returns.
- Reset is taken regardless of state. An in-flight response arriving after reset is ignored, because `outstanding` = 0.

## Configuration
- `IFETCH_JFOLD_EN` defined:
  - A non-dropped response with opcode `4'b1000` (J) is not pushed.
  - Instead, `pc` ← `imem_rdata[ADDR_W-1:0]`, and any already-buffered words remain.
  - A same-cycle `jump_valid` takes priority, and the J is discarded.
- Undefined: J words are pushed like any other instruction, and redirection relies on `jump_valid`.

## Test plan
- Reset, then zero-wait memory returning `0x0000+addr`, `instr_ready` = 1: words at addresses 0,1,2,… appear in order, with `instr_valid` first high 3 cycles after reset release.
- `instr_ready` = 0 for 20 cycles: exactly DEPTH = 4 words are buffered, `imem_req` stays 0 afterwards, and no data is lost when `instr_ready` rises.
- Memory latency of 3 cycles, `jump_valid` with `jump_target` = 0x100 asserted while a read of 0x005 is outstanding: the 0x005 data is dropped, the next `instr_pc` is 0x100, and the FIFO is empty the cycle after the jump.
- `pc` = 0xFFF: the next request address is 0x000.
- `IFETCH_JFOLD_EN` defined, address 0x010 holds `0x8040`: the J word never appears on `instr`, and the word following 0x00F is the one from 0x040.
- `imem_rvalid` pulsed with nothing outstanding: `count` and `pc` are unchanged.
